// File: rtl/drfuzz_pkg.sv
// Shared types and sizing helpers for the coverage run controller.
package drfuzz_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    META  = 3'd1,
    RST   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  function automatic int num_words(input int cover_w, input int out_w);
    return (cover_w + out_w - 1) / out_w;
  endfunction

  function automatic int padded_w(input int cover_w, input int out_w);
    return num_words(cover_w, out_w) * out_w;
  endfunction

endpackage

// File: rtl/drfuzz_popcount.sv
// Combinational count of set bits in a W-bit vector.
module drfuzz_popcount #(
  parameter int W    = 32,
  parameter int CntW = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_vec,
  output logic [CntW-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + CntW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/drfuzz_cover_collector.sv
// Fuzz-run sequencer: resets and runs the DUT, collects sticky coverage,
// streams the run map and merges it into a cumulative map.
//
//   state | meaning
//   IDLE  | DUT held in reset, waiting for start; cumulative clear allowed
//   META  | meta reset asserted for MetaRstCycles cycles
//   RST   | plain reset asserted for DutRstCycles cycles
//   RUN   | DUT free-running for run_len cycles, cover_i ORed into run map
//   DRAIN | run map streamed word by word and merged into cumulative map
module drfuzz_cover_collector
  import drfuzz_pkg::*;
#(
  parameter int CoverW        = 172,
  parameter int OutW          = 32,
  parameter int CycleW        = 32,
  parameter int MetaRstCycles = 4,
  parameter int DutRstCycles  = 4,
  localparam int CntW         = $clog2(CoverW + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CycleW-1:0] run_len_i,
  input  logic              clear_cum_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dut_meta_rst_no,
  output logic              dut_rst_no,
  input  logic [CoverW-1:0] cover_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [OutW-1:0]   m_data_o,
  output logic              m_last_o,
  output logic [CntW-1:0]   new_cnt_o,
  output logic [CntW-1:0]   total_cnt_o
);

  localparam int NumWords = num_words(CoverW, OutW);
  localparam int PadW     = padded_w(CoverW, OutW);
  localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int PopW     = $clog2(OutW + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CycleW-1:0] r_run_len;
  logic [CycleW-1:0] r_timer;
  logic [IdxW-1:0]   r_word_idx;
  logic [CntW-1:0]   r_new_cnt;
  logic [CntW-1:0]   r_total_cnt;
  logic              r_done;
  logic [OutW-1:0]   r_run_map [NumWords];
  logic [OutW-1:0]   r_cum_map [NumWords];

  logic [PadW-1:0]   w_cover_pad;
  logic [OutW-1:0]   w_cover_words [NumWords];
  logic [OutW-1:0]   w_cur_word;
  logic [OutW-1:0]   w_new_bits;
  logic [PopW-1:0]   w_pop;
  logic              w_tc;
  logic              w_last;
  logic              w_beat;

  // Pad bits above CoverW are forced to zero so the last word streams clean.
  assign w_cover_pad = PadW'(cover_i);

  always_comb begin
    for (int w = 0; w < NumWords; w++) begin
      w_cover_words[w] = w_cover_pad[w*OutW +: OutW];
    end
  end

  assign w_cur_word = r_run_map[r_word_idx];
  assign w_new_bits = w_cur_word & ~r_cum_map[r_word_idx];
  assign w_tc       = (r_timer == '0);
  assign w_last     = (r_word_idx == IdxW'(NumWords - 1));
  assign w_beat     = (r_state == DRAIN) && m_ready_i;

  drfuzz_popcount #(
    .W    (OutW),
    .CntW (PopW)
  ) u_popcount (
    .i_vec (w_new_bits),
    .o_cnt (w_pop)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = META;
      META:    if (w_tc) w_state_nxt = RST;
      RST:     if (w_tc) w_state_nxt = (r_run_len == '0) ? DRAIN : RUN;
      RUN:     if (w_tc) w_state_nxt = DRAIN;
      DRAIN:   if (w_beat && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_run_len   <= '0;
      r_timer     <= '0;
      r_word_idx  <= '0;
      r_new_cnt   <= '0;
      r_total_cnt <= '0;
      r_done      <= 1'b0;
      for (int w = 0; w < NumWords; w++) begin
        r_run_map[w] <= '0;
        r_cum_map[w] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_cum_i) begin
            r_total_cnt <= '0;
            for (int w = 0; w < NumWords; w++) r_cum_map[w] <= '0;
          end
          if (start_i) begin
            r_run_len  <= run_len_i;
            r_new_cnt  <= '0;
            r_word_idx <= '0;
            r_timer    <= CycleW'(MetaRstCycles - 1);
            for (int w = 0; w < NumWords; w++) r_run_map[w] <= '0;
          end
        end
        META: begin
          r_timer <= w_tc ? CycleW'(DutRstCycles - 1) : r_timer - 1'b1;
        end
        RST: begin
          // With run_len = 0 the reload value is never used.
          r_timer <= w_tc ? r_run_len - 1'b1 : r_timer - 1'b1;
        end
        RUN: begin
          if (!w_tc) r_timer <= r_timer - 1'b1;
          for (int w = 0; w < NumWords; w++) begin
            r_run_map[w] <= r_run_map[w] | w_cover_words[w];
          end
        end
        DRAIN: begin
          if (w_beat) begin
            r_new_cnt             <= r_new_cnt + CntW'(w_pop);
            r_total_cnt           <= r_total_cnt + CntW'(w_pop);
            r_cum_map[r_word_idx] <= r_cum_map[r_word_idx] | w_cur_word;
            if (w_last) begin
              r_done     <= 1'b1;
              r_word_idx <= '0;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
  assign dut_meta_rst_no = (r_state != META);
  assign dut_rst_no      = (r_state == RUN) || (r_state == DRAIN);
  assign m_valid_o       = (r_state == DRAIN);
  assign m_data_o        = w_cur_word;
  assign m_last_o        = (r_state == DRAIN) && w_last;
  assign new_cnt_o       = r_new_cnt;
  assign total_cnt_o     = r_total_cnt;

endmodule

// File: tb/tb_drfuzz_cover_collector.sv
// Scoreboard bench: expected stream words and counts come from a bench-side coverage model.
module tb_drfuzz_cover_collector;

  localparam int CoverW = 172;
  localparam int OutW   = 32;
  localparam int NW     = 6;
  localparam int CntW   = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [31:0]       run_len_i;
  logic              clear_cum_i;
  logic              busy_o, done_o, dut_meta_rst_no, dut_rst_no;
  logic [CoverW-1:0] cover_i;
  logic              m_valid_o, m_ready_i, m_last_o;
  logic [OutW-1:0]   m_data_o;
  logic [CntW-1:0]   new_cnt_o, total_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [CoverW-1:0] cum_m;
  logic [CoverW-1:0] cov_tab [64];
  logic [OutW:0]     exp_q [$];

  always #5 clk_i = ~clk_i;

  drfuzz_cover_collector dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .run_len_i       (run_len_i),
    .clear_cum_i     (clear_cum_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .dut_meta_rst_no (dut_meta_rst_no),
    .dut_rst_no      (dut_rst_no),
    .cover_i         (cover_i),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .m_data_o        (m_data_o),
    .m_last_o        (m_last_o),
    .new_cnt_o       (new_cnt_o),
    .total_cnt_o     (total_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [CoverW-1:0] v);
    int n = 0;
    for (int i = 0; i < CoverW; i++) n += int'(v[i]);
    return n;
  endfunction

  // mode 0: bit5 in RUN cycle 3; 1: all ones always; 2: all ones in RUN only;
  // 3: edge bits just outside/inside RUN; 4: sparse random during RUN.
  task automatic do_run(input int len, input int mode, input int rmode,
                        input bit clr, input int abort_k, input bit poke);
    logic [CoverW-1:0] run_exp;
    logic [191:0]      tmp;
    logic [191:0]      pad;
    logic [OutW:0]     e;
    logic [OutW-1:0]   hold_d;
    logic              hold_l;
    bit                hold_v = 0;
    bit                fin = 0;
    int                beats = 0, meta_lo = 0, rst_lo = 0, dones = 0, c = 0;
    int                exp_new;

    for (int i = 0; i < 64; i++) begin
      cov_tab[i] = '0;
      case (mode)
        0: if (i == 11) cov_tab[i][5] = 1'b1;
        1: cov_tab[i] = '1;
        2: if (i >= 8 && i < 8 + len) cov_tab[i] = '1;
        3: begin
          if (i == 7)           cov_tab[i][9]   = 1'b1;
          if (i == 8)           cov_tab[i][100] = 1'b1;
          if (i == 8 + len - 1) cov_tab[i][171] = 1'b1;
          if (i == 8 + len)     cov_tab[i][11]  = 1'b1;
        end
        default: if (i >= 8 && i < 8 + len) begin
          tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}
              & {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}
              & {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          cov_tab[i] = tmp[CoverW-1:0];
        end
      endcase
    end

    if (clr) cum_m = '0;
    run_exp = '0;
    for (int i = 8; i < 8 + len; i++) run_exp |= cov_tab[i];
    exp_new = popc(run_exp & ~cum_m);
    cum_m   = cum_m | run_exp;
    pad     = {20'b0, run_exp};
    for (int w = 0; w < NW; w++) exp_q.push_back({(w == NW - 1), pad[w*OutW +: OutW]});

    start_i     = 1'b1;
    run_len_i   = len;
    clear_cum_i = clr;
    @(negedge clk_i);
    run_len_i = $urandom;

    while (!fin && c < 400) begin
      cover_i     = cov_tab[(c < 64) ? c : 63];
      start_i     = poke && (c == 10);
      clear_cum_i = poke && (c == 10);
      case (rmode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = (c % 2 == 0);
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (!dut_rst_no)      rst_lo++;
      if (!dut_meta_rst_no) meta_lo++;
      if (done_o)           dones++;
      if (hold_v) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, hold_d);
        chk("hold_last", m_last_o, hold_l);
      end
      hold_v = 0;
      if (m_valid_o) begin
        if (beats == abort_k) begin
          rst_i = 1'b1;
          m_ready_i = 1'b0;
          @(negedge clk_i);
          rst_i = 1'b0;
          start_i = 1'b0;
          clear_cum_i = 1'b0;
          chk("abort_valid", m_valid_o, 0);
          chk("abort_busy", busy_o, 0);
          chk("abort_total", total_cnt_o, 0);
          chk("abort_rstn", dut_rst_no, 0);
          exp_q.delete();
          cum_m = '0;
          cover_i = '0;
          return;
        end
        if (m_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_data_o, e[OutW-1:0]);
            chk("beat_last", m_last_o, e[OutW]);
            if (e[OutW]) fin = 1;
          end
          beats++;
        end else begin
          hold_v = 1;
          hold_d = m_data_o;
          hold_l = m_last_o;
        end
      end
      @(negedge clk_i);
      c++;
    end
    start_i     = 1'b0;
    clear_cum_i = 1'b0;
    m_ready_i   = 1'b0;
    cover_i     = '0;

    if (!fin) chk("timeout", 0, 1);
    chk("early_done", dones, 0);
    chk("beats", beats, NW);
    chk("meta_low", meta_lo, 4);
    chk("rst_low", rst_lo, 8);
    chk("done_pulse", done_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_rstn", dut_rst_no, 0);
    chk("new_cnt", new_cnt_o, exp_new);
    chk("total_cnt", total_cnt_o, popc(cum_m));
    @(negedge clk_i);
    chk("done_once", done_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; run_len_i = '0; clear_cum_i = 1'b0;
    cover_i = '0; m_ready_i = 1'b0;
    cum_m = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_meta", dut_meta_rst_no, 1);
    chk("rst_rstn", dut_rst_no, 0);
    chk("rst_new", new_cnt_o, 0);
    chk("rst_total", total_cnt_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    do_run(10, 0, 0, 0, -1, 0);
    chk("t1_new_const", new_cnt_o, 1);
    do_run(10, 0, 0, 0, -1, 0);
    chk("t2_new_const", new_cnt_o, 0);
    chk("t2_total_const", total_cnt_o, 1);
    do_run(10, 0, 0, 1, -1, 0);
    chk("t2_clr_new", new_cnt_o, 1);

    do_run(7, 4, 0, 0, -1, 0);
    clear_cum_i = 1'b1;
    @(negedge clk_i);
    clear_cum_i = 1'b0;
    cum_m = '0;
    chk("clr_total", total_cnt_o, 0);

    do_run(0, 1, 0, 0, -1, 0);
    do_run(10, 2, 1, 0, -1, 0);
    chk("t4_new_const", new_cnt_o, 172);

    do_run(10, 2, 0, 0, 2, 0);
    do_run(5, 3, 0, 0, -1, 0);
    do_run(12, 3, 0, 0, -1, 1);

    for (int r = 0; r < 6; r++) do_run($urandom_range(1, 20), 4, 2, (r == 3), -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
